// File: rtl/h14tx_pkg.sv
// Shared types for the HDMI 1.4 transmit path.
package h14tx_pkg;

    typedef enum logic [1:0] {
        PERIOD_CONTROL  = 2'd0,
        PERIOD_PREAMBLE = 2'd1,
        PERIOD_VIDEO_GB = 2'd2,
        PERIOD_VIDEO    = 2'd3
    } period_t;

    typedef logic [1:0] ctl_t;

    localparam ctl_t CTL_PREAMBLE_VIDEO_CH1 = 2'b01;
    localparam ctl_t CTL_PREAMBLE_VIDEO_CH2 = 2'b00;

    typedef struct packed {
        logic        de;
        logic        hsync;
        logic        vsync;
        logic [23:0] pixel;
    } tx_sample_t;

endpackage

// File: rtl/h14tx_period_sched.sv
// Period scheduler: delays timing/pixels so every video period is
// preceded by a video preamble and guard band.
module h14tx_period_sched
    import h14tx_pkg::*;
#(
    parameter int PRE_LEN     = 8,
    parameter int GB_LEN      = 2,
    parameter int MIN_CTL_LEN = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        de,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [23:0] pixel,
    output period_t     period,
    output ctl_t        ctl0,
    output ctl_t        ctl1,
    output ctl_t        ctl2,
    output logic [23:0] pixel_o,
    output logic        err_short_blank
);

    localparam int D      = PRE_LEN + GB_LEN + 1;
    localparam int DEPTH  = D - 1;
    localparam int CD_MAX = PRE_LEN + GB_LEN;
    localparam int CDW    = $clog2(CD_MAX + 1);
    localparam int RW     = $clog2(MIN_CTL_LEN + 1);

    localparam logic [CDW-1:0] CD_LOAD = CDW'(CD_MAX);
    localparam logic [CDW-1:0] CD_GB   = CDW'(GB_LEN);
    localparam logic [RW-1:0]  RUN_MAX = RW'(MIN_CTL_LEN);

    tx_sample_t       in_s;
    tx_sample_t       dl [DEPTH];
    tx_sample_t       tail;
    logic             de_prev;
    logic             rise;
    logic [CDW-1:0]   countdown;
    logic [CDW-1:0]   cd_next;
    logic [RW-1:0]    run;
    logic [RW-1:0]    run_next;
    logic             err_next;
    period_t          per_next;
    ctl_t             ctl1_next;
    ctl_t             ctl2_next;

    assign in_s = '{de: de, hsync: hsync, vsync: vsync, pixel: pixel};
    assign tail = dl[DEPTH-1];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_dl
            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (rst) dl[gi] <= '0;
                    else     dl[gi] <= in_s;
                end
            end else begin : g_body
                always_ff @(posedge clk) begin
                    if (rst) dl[gi] <= '0;
                    else     dl[gi] <= dl[gi-1];
                end
            end
        end
    endgenerate

    // cd_next is the countdown as seen by the sample leaving the line
    // this cycle, so a rise classifies that sample immediately.
    always_comb begin
        rise    = de & ~de_prev;
        cd_next = '0;
        if (rise)
            cd_next = CD_LOAD;
        else if (countdown != '0)
            cd_next = countdown - CDW'(1);
    end

    always_comb begin
        run_next = run;
        if (de)
            run_next = '0;
        else if (run < RUN_MAX)
            run_next = run + RW'(1);
        err_next = rise & (run < RUN_MAX);
    end

    always_comb begin
        per_next  = PERIOD_CONTROL;
        ctl1_next = 2'b00;
        ctl2_next = 2'b00;
        unique case (1'b1)
            tail.de: begin
                per_next = PERIOD_VIDEO;
            end
            !tail.de && cd_next != '0 && cd_next <= CD_GB: begin
                per_next = PERIOD_VIDEO_GB;
            end
            !tail.de && cd_next > CD_GB: begin
                per_next  = PERIOD_PREAMBLE;
                ctl1_next = CTL_PREAMBLE_VIDEO_CH1;
                ctl2_next = CTL_PREAMBLE_VIDEO_CH2;
            end
            default: begin
                per_next = PERIOD_CONTROL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            de_prev   <= 1'b0;
            countdown <= '0;
            run       <= '0;
        end else begin
            de_prev   <= de;
            countdown <= cd_next;
            run       <= run_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            period          <= PERIOD_CONTROL;
            ctl0            <= 2'b00;
            ctl1            <= 2'b00;
            ctl2            <= 2'b00;
            pixel_o         <= '0;
            err_short_blank <= 1'b0;
        end else begin
            period          <= per_next;
            ctl0            <= {tail.vsync, tail.hsync};
            ctl1            <= ctl1_next;
            ctl2            <= ctl2_next;
            pixel_o         <= tail.pixel;
            err_short_blank <= err_next;
        end
    end

endmodule

// File: tb/tb_h14tx_period_sched.sv
// Randomized bench for h14tx_period_sched against a cycle-indexed
// reference built from the period rules.
module tb_h14tx_period_sched;
    import h14tx_pkg::*;

    localparam int N    = 1500;
    localparam int PG   = 10;
    localparam int GB   = 2;
    localparam int MINC = 12;
    localparam int LAT  = 11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        de = 1'b0;
    logic        hsync = 1'b0;
    logic        vsync = 1'b0;
    logic [23:0] pixel = '0;
    period_t     period;
    ctl_t        ctl0;
    ctl_t        ctl1;
    ctl_t        ctl2;
    logic [23:0] pixel_o;
    logic        err_short_blank;

    always #5 clk = ~clk;

    h14tx_period_sched dut (
        .clk             (clk),
        .rst             (rst),
        .de              (de),
        .hsync           (hsync),
        .vsync           (vsync),
        .pixel           (pixel),
        .period          (period),
        .ctl0            (ctl0),
        .ctl1            (ctl1),
        .ctl2            (ctl2),
        .pixel_o         (pixel_o),
        .err_short_blank (err_short_blank)
    );

    bit          de_h [N];
    bit          hs_h [N];
    bit          vs_h [N];
    bit          rst_h[N];
    logic [23:0] px_h [N];
    int          pos;
    int          checks;
    int          failures;
    int          cyc;

    task automatic chk(input string tag, input int unsigned got,
                       input int unsigned exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic put(input bit d, input bit h, input bit v, input bit r);
        if (pos < N) begin
            de_h[pos]  = d;
            hs_h[pos]  = h;
            vs_h[pos]  = v;
            rst_h[pos] = r;
            px_h[pos]  = 24'($urandom);
            pos++;
        end
    endtask

    function automatic bit is_rst(input int p);
        if (p < 0) return 1'b1;
        return rst_h[p];
    endfunction

    function automatic bit rise_at(input int q);
        if (q < 0) return 1'b0;
        if (is_rst(q - 1)) return de_h[q];
        return de_h[q] && !de_h[q-1];
    endfunction

    // Remaining preamble+guard slots implied by the latest rise at or
    // before cycle m that no reset has wiped out.
    function automatic int cd_at(input int m);
        for (int k = 0; k < PG; k++) begin
            int q = m - k;
            if (q < 0) break;
            if (k > 0 && is_rst(q)) break;
            if (rise_at(q)) return PG - k;
        end
        return 0;
    endfunction

    function automatic int run_at(input int q);
        int n = 0;
        int p = q - 1;
        while (n < MINC && !is_rst(p) && !de_h[p]) begin
            n++;
            p--;
        end
        return n;
    endfunction

    task automatic check_cycle(input int c);
        int          m = c - 1;
        int          s = c - LAT;
        bit          clr;
        bit          sd;
        bit          sh;
        bit          sv;
        logic [23:0] sp;
        int          cd;
        period_t     ep;
        bit          ee;
        if (is_rst(m)) begin
            chk("rst_period", period, PERIOD_CONTROL);
            chk("rst_ctl0", ctl0, 0);
            chk("rst_ctl1", ctl1, 0);
            chk("rst_ctl2", ctl2, 0);
            chk("rst_pixel", pixel_o, 0);
            chk("rst_err", err_short_blank, 0);
            return;
        end
        clr = (s < 0);
        for (int x = s; x <= s + PG - 1; x++)
            if (is_rst(x)) clr = 1'b1;
        sd = clr ? 1'b0 : de_h[s];
        sh = clr ? 1'b0 : hs_h[s];
        sv = clr ? 1'b0 : vs_h[s];
        sp = clr ? 24'd0 : px_h[s];
        cd = cd_at(m);
        if (sd)            ep = PERIOD_VIDEO;
        else if (cd == 0)  ep = PERIOD_CONTROL;
        else if (cd <= GB) ep = PERIOD_VIDEO_GB;
        else               ep = PERIOD_PREAMBLE;
        ee = rise_at(m) && (run_at(m) < MINC);
        chk("period", period, ep);
        chk("ctl0", ctl0, {sv, sh});
        chk("ctl1", ctl1, (ep == PERIOD_PREAMBLE) ? 1 : 0);
        chk("ctl2", ctl2, 0);
        chk("err", err_short_blank, ee);
        if (ep == PERIOD_VIDEO)
            chk("pixel", pixel_o, sp);
    endtask

    task automatic build_stimulus();
        bit h;
        bit v;
        pos = 0;
        repeat (3)  put(0, 0, 0, 1);
        repeat (20) put(0, 1, 0, 0);
        repeat (16) put(1, 1, 0, 0);
        repeat (5)  put(0, 0, 1, 0);
        repeat (16) put(1, 0, 1, 0);
        repeat (12) put(0, 1, 1, 0);
        repeat (8)  put(1, 0, 0, 0);
        repeat (11) put(0, 1, 0, 0);
        repeat (10) put(1, 0, 0, 0);
        put(1, 0, 0, 1);
        repeat (12) put(1, 0, 0, 0);
        repeat (14) put(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
        repeat (100) put(0, 0, 0, 0);
        while (pos < N - 30) begin
            if ($urandom_range(0, 11) == 0)
                put(1'($urandom_range(0, 1)), 0, 0, 1);
            h = 1'($urandom_range(0, 1));
            v = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 24)) begin
                if ($urandom_range(0, 5) == 0) h = ~h;
                put(0, h, v, 0);
            end
            repeat ($urandom_range(1, 30)) put(1, h, v, 0);
        end
        while (pos < N) put(0, 0, 0, 0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        build_stimulus();
        @(posedge clk);
        #1;
        for (int c = 0; c < N; c++) begin
            cyc = c;
            if (c >= 1) check_cycle(c);
            rst   = rst_h[c];
            de    = de_h[c];
            hsync = hs_h[c];
            vsync = vs_h[c];
            pixel = px_h[c];
            @(posedge clk);
            #1;
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
